// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the bit-serial sequence detectors: takes a word over
// valid/ready, emits it one bit per DIV clocks with a sampling strobe and an end-of-frame pulse.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DPRE  = DW'(DIV - 2);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_bit_feeder: WIDTH must be at least 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("serial_bit_feeder: DIV must be at least 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic [BW-1:0]    bcnt_q, bcnt_n;
  logic [DW-1:0]    dcnt_q, dcnt_n;
  logic             bit_out_n;
  logic             bit_en_n;
  logic             frame_done_n;

  // Bit that leaves first when a word is loaded.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  // Bit that becomes current after the next shift.
  function automatic logic next_bit(input logic [WIDTH-1:0] s);
    if (MSB_FIRST != 0) return s[WIDTH-2];
    else                return s[1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] s);
    if (MSB_FIRST != 0) return {s[WIDTH-2:0], 1'b0};
    else                return {1'b0, s[WIDTH-1:1]};
  endfunction

  assign din_ready = (state_q == IDLE) & ~clear;

  always_comb begin
    state_n      = state_q;
    sreg_n       = sreg_q;
    bcnt_n       = bcnt_q;
    dcnt_n       = dcnt_q;
    bit_out_n    = bit_out;
    bit_en_n     = 1'b0;
    frame_done_n = 1'b0;

    if (clear) begin
      state_n   = IDLE;
      sreg_n    = '0;
      bcnt_n    = '0;
      dcnt_n    = '0;
      bit_out_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (din_valid && din_ready) begin
            state_n   = SHIFT;
            sreg_n    = din;
            bcnt_n    = '0;
            dcnt_n    = '0;
            bit_out_n = first_bit(din);
          end
        end
        SHIFT: begin
          dcnt_n = (dcnt_q == DLAST) ? '0 : dcnt_q + DW'(1);
          // Strobe lands in the last clock of the bit period, after DIV-1 settled clocks.
          if (dcnt_q == DPRE) bit_en_n = 1'b1;
          if (dcnt_q == DLAST) begin
            if (bcnt_q == BLAST) begin
              state_n      = IDLE;
              frame_done_n = 1'b1;
              bit_out_n    = 1'b0;
            end else begin
              sreg_n    = shift_word(sreg_q);
              bcnt_n    = bcnt_q + BW'(1);
              bit_out_n = next_bit(sreg_q);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bcnt_q     <= '0;
      dcnt_q     <= '0;
      bit_out    <= 1'b0;
      bit_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      sreg_q     <= sreg_n;
      bcnt_q     <= bcnt_n;
      dcnt_q     <= dcnt_n;
      bit_out    <= bit_out_n;
      bit_en     <= bit_en_n;
      busy       <= (state_n == SHIFT);
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first and an LSB-first instance (WIDTH=8, DIV=4)
// on a shared clock and reset.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       m_clear = 1'b0, m_valid = 1'b0;
  logic [7:0] m_din = '0;
  logic       m_ready, m_bit, m_en, m_busy, m_done;

  logic       l_clear = 1'b0, l_valid = 1'b0;
  logic [7:0] l_din = '0;
  logic       l_ready, l_bit, l_en, l_busy, l_done;

  serial_bit_feeder #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clear(m_clear), .din(m_din), .din_valid(m_valid),
    .din_ready(m_ready), .bit_out(m_bit), .bit_en(m_en), .busy(m_busy), .frame_done(m_done)
  );

  serial_bit_feeder #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clear(l_clear), .din(l_din), .din_valid(l_valid),
    .din_ready(l_ready), .bit_out(l_bit), .bit_en(l_en), .busy(l_busy), .frame_done(l_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in cycle k+1 (just after the accepting edge k); returns in cycle k+33.
  // Vector order: {bit_out, bit_en, busy, frame_done, din_ready}.
  task automatic check_frame(input bit msb, input string tag, input logic [7:0] exp_seq,
                             output logic [7:0] got_seq);
    logic [4:0] obs, exp;
    int ns;
    ns = 0;
    got_seq = '0;
    for (int j = 0; j <= 32; j++) begin
      obs = msb ? {m_bit, m_en, m_busy, m_done, m_ready} : {l_bit, l_en, l_busy, l_done, l_ready};
      if (j < 32) exp = {exp_seq[7 - j / 4], (j % 4 == 3), 1'b1, 1'b0, 1'b0};
      else        exp = 5'b00011;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle k+%0d: {bit,en,busy,done,ready} got %b expected %b", tag, j + 1, obs, exp);
      end
      if (obs[3] === 1'b1 && ns < 8) begin
        got_seq[7 - ns] = obs[4];
        ns++;
      end
      if (j < 32) tick();
    end
    n_checks++;
    if (got_seq !== exp_seq) begin
      n_fail++;
      $display("FAIL %s strobed sequence: got %b expected %b", tag, got_seq, exp_seq);
    end
  endtask

  task automatic test_reset;
    m_valid = 1'b1;
    l_valid = 1'b1;
    m_din   = 8'hFF;
    l_din   = 8'hFF;
    repeat (3) tick();
    n_checks++;
    if ({m_bit, m_en, m_busy, m_done, m_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_msb_held: got %b expected %b", {m_bit, m_en, m_busy, m_done, m_ready}, 5'b00001);
    end
    n_checks++;
    if ({l_bit, l_en, l_busy, l_done, l_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_lsb_held: got %b expected %b", {l_bit, l_en, l_busy, l_done, l_ready}, 5'b00001);
    end
    m_valid = 1'b0;
    l_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    n_checks++;
    if ({m_bit, m_en, m_busy, m_done, m_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_msb_idle: got %b expected %b", {m_bit, m_en, m_busy, m_done, m_ready}, 5'b00001);
    end
    n_checks++;
    if ({l_bit, l_en, l_busy, l_done, l_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_lsb_idle: got %b expected %b", {l_bit, l_en, l_busy, l_done, l_ready}, 5'b00001);
    end
  endtask

  task automatic test_msb_frame;
    logic [7:0] got;
    int hits;
    m_din   = 8'b0110_0110;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    check_frame(1'b1, "msb_frame", 8'b0110_0110, got);
    hits = 0;
    for (int i = 0; i <= 4; i++)
      if (got[7 - i -: 4] == 4'b0110) hits++;
    n_checks++;
    if (hits !== 2) begin
      n_fail++;
      $display("FAIL msb_frame detector hits: got %0d expected %0d", hits, 2);
    end
  endtask

  task automatic test_lsb_frame;
    logic [7:0] got;
    l_din   = 8'hA5;
    l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    check_frame(1'b0, "lsb_frame", 8'b1010_0101, got);
  endtask

  task automatic test_back_to_back;
    logic [7:0] got;
    m_din   = 8'hFF;
    m_valid = 1'b1;
    tick();
    m_din = 8'h00;
    check_frame(1'b1, "b2b_first", 8'hFF, got);
    tick();
    m_valid = 1'b0;
    check_frame(1'b1, "b2b_second", 8'h00, got);
  endtask

  task automatic test_abort;
    logic [7:0] got;
    m_din   = 8'hC3;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    repeat (11) tick();
    n_checks++;
    if (m_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort third strobe: got %b expected %b", m_en, 1'b1);
    end
    m_clear = 1'b1;
    m_valid = 1'b1;
    m_din   = 8'h5A;
    #1;
    n_checks++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort ready_during_clear: got %b expected %b", m_ready, 1'b0);
    end
    tick();
    m_clear = 1'b0;
    #1;
    n_checks++;
    if ({m_bit, m_en, m_busy, m_done, m_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL abort after_clear: got %b expected %b", {m_bit, m_en, m_busy, m_done, m_ready}, 5'b00001);
    end
    tick();
    m_valid = 1'b0;
    check_frame(1'b1, "abort_fresh", 8'h5A, got);
  endtask

  task automatic test_async_reset;
    logic [7:0] got;
    m_din   = 8'hFF;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    repeat (21) tick();
    n_checks++;
    if ({m_bit, m_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL async bit5 active: got %b expected %b", {m_bit, m_busy}, 2'b11);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_bit, m_en, m_busy, m_done, m_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async immediate: got %b expected %b", {m_bit, m_en, m_busy, m_done, m_ready}, 5'b00001);
    end
    repeat (2) tick();
    n_checks++;
    if ({m_bit, m_en, m_busy, m_done, m_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async held: got %b expected %b", {m_bit, m_en, m_busy, m_done, m_ready}, 5'b00001);
    end
    rst_n = 1'b1;
    tick();
    m_din   = 8'h96;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    check_frame(1'b1, "post_reset", 8'h96, got);
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
